// File: rtl/scie_job_scheduler.sv
// scie_job_scheduler
//   Round-robin front end for the shared SCIE complex-arithmetic pipeline. Each granted request is
//   either a coefficient write (insn 11, rs2 = tap index) or a compute job (insn 43, bubble,
//   insn 91, result capture, response). One job is in flight at a time.
//
// Ports
//   i_clock, i_reset            clock (rising edge) and asynchronous active-low reset
//   i_req_valid/o_req_ready     per-requester handshake; o_req_ready is a one-hot accept pulse
//   i_req_cfg/_idx/_real/_imag  per-requester request fields, flattened, requester 0 in the LSBs
//   o_resp_*/i_resp_ready       compute result with owning requester id
//   o_cfg_err                   pulse: coefficient write dropped because idx >= NUM_TAPS
//   o_acc_*/i_acc_rd_*          accelerator io_valid/io_insn/io_rs1/io_rs2/io_rd
//
// Optional feature: define SCIE_SCHED_PERF_EN to add o_perf_jobs, o_perf_busy, o_perf_cfg.
//
// All outputs are registered. The output registers are loaded from the decode of the current
// state, so what a state drives becomes visible on the cycle after that state is occupied.
module scie_job_scheduler #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_TAPS = 5,
  parameter int unsigned IDX_W    = 3,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ-1:0]        i_req_cfg,
  input  logic [NUM_REQ*IDX_W-1:0]  i_req_idx,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_real,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_imag,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [ID_W-1:0]           o_resp_id,
  output logic [DATA_W-1:0]         o_resp_real,
  output logic [DATA_W-1:0]         o_resp_imag,
  output logic                      o_cfg_err,
`ifdef SCIE_SCHED_PERF_EN
  output logic [31:0]               o_perf_jobs,
  output logic [31:0]               o_perf_busy,
  output logic [15:0]               o_perf_cfg,
`endif
  output logic                      o_acc_valid,
  output logic [31:0]               o_acc_insn,
  output logic [DATA_W-1:0]         o_acc_rs1_real,
  output logic [DATA_W-1:0]         o_acc_rs1_imag,
  output logic [31:0]               o_acc_rs2,
  input  logic [DATA_W-1:0]         i_acc_rd_real,
  input  logic [DATA_W-1:0]         i_acc_rd_imag
);

  localparam logic [31:0] InsnCfg  = 32'd11;
  localparam logic [31:0] InsnLoad = 32'd43;
  localparam logic [31:0] InsnComp = 32'd91;

  typedef enum logic [2:0] {StIdle, StCfg, StData, StBub, StComp, StCap, StResp} state_e;

  state_e r_state, w_state_d;

  // Arbitration and latched request
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt_found;
  logic              w_grant;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_op_real, r_op_imag;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       w_idx_ext;
  logic              w_idx_ok;

  // Output registers and their next values
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_d;
  logic               r_acc_valid, w_acc_valid_d;
  logic [31:0]        r_acc_insn, w_acc_insn_d;
  logic [DATA_W-1:0]  r_rs1_real, w_rs1_real_d;
  logic [DATA_W-1:0]  r_rs1_imag, w_rs1_imag_d;
  logic [31:0]        r_rs2, w_rs2_d;
  logic               r_resp_valid, w_resp_valid_d;
  logic [ID_W-1:0]    r_resp_id, w_resp_id_d;
  logic [DATA_W-1:0]  r_resp_real, w_resp_real_d;
  logic [DATA_W-1:0]  r_resp_imag, w_resp_imag_d;
  logic               r_cfg_err, w_cfg_err_d;

  // First valid requester at or after the pointer; NUM_REQ is a power of two so the add wraps.
  always_comb begin
    logic [ID_W-1:0] cand;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = r_ptr + ID_W'(i);
      if (!w_gnt_found && i_req_valid[cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = cand;
      end
    end
  end

  assign w_grant   = (r_state == StIdle) && w_gnt_found;
  assign w_idx_ext = {{(32-IDX_W){1'b0}}, r_idx};
  assign w_idx_ok  = w_idx_ext < NUM_TAPS;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_req_ready_d  = '0;
    w_acc_valid_d  = 1'b0;
    w_acc_insn_d   = r_acc_insn;
    w_rs1_real_d   = r_rs1_real;
    w_rs1_imag_d   = r_rs1_imag;
    w_rs2_d        = r_rs2;
    w_resp_valid_d = r_resp_valid;
    w_resp_id_d    = r_resp_id;
    w_resp_real_d  = r_resp_real;
    w_resp_imag_d  = r_resp_imag;
    w_cfg_err_d    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_id;
          w_state_d     = i_req_cfg[w_gnt_id] ? StCfg : StData;
        end
      end
      StCfg: begin
        if (w_idx_ok) begin
          w_acc_valid_d = 1'b1;
          w_acc_insn_d  = InsnCfg;
          w_rs1_real_d  = r_op_real;
          w_rs1_imag_d  = r_op_imag;
          w_rs2_d       = w_idx_ext;
        end else begin
          w_cfg_err_d = 1'b1;
        end
        w_state_d = StIdle;
      end
      StData: begin
        w_acc_valid_d = 1'b1;
        w_acc_insn_d  = InsnLoad;
        w_rs1_real_d  = r_op_real;
        w_rs1_imag_d  = r_op_imag;
        w_rs2_d       = '0;
        w_state_d     = StBub;
      end
      StBub: begin
        w_state_d = StComp;
      end
      StComp: begin
        w_acc_valid_d = 1'b1;
        w_acc_insn_d  = InsnComp;
        w_state_d     = StCap;
      end
      StCap: begin
        w_resp_id_d   = r_id;
        w_resp_real_d = i_acc_rd_real;
        w_resp_imag_d = i_acc_rd_imag;
        w_state_d     = StResp;
      end
      StResp: begin
        // First RESP cycle raises resp_valid; the handshake is taken on the registered flag.
        if (r_resp_valid && i_resp_ready) begin
          w_resp_valid_d = 1'b0;
          w_state_d      = StIdle;
        end else begin
          w_resp_valid_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr     <= '0;
      r_idx     <= '0;
      r_op_real <= '0;
      r_op_imag <= '0;
      r_id      <= '0;
    end else if (w_grant) begin
      r_ptr     <= w_gnt_id + ID_W'(1);
      r_idx     <= i_req_idx[w_gnt_id*IDX_W +: IDX_W];
      r_op_real <= i_req_real[w_gnt_id*DATA_W +: DATA_W];
      r_op_imag <= i_req_imag[w_gnt_id*DATA_W +: DATA_W];
      r_id      <= w_gnt_id;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_req_ready  <= '0;
      r_acc_valid  <= 1'b0;
      r_acc_insn   <= '0;
      r_rs1_real   <= '0;
      r_rs1_imag   <= '0;
      r_rs2        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_real  <= '0;
      r_resp_imag  <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_d;
      r_acc_valid  <= w_acc_valid_d;
      r_acc_insn   <= w_acc_insn_d;
      r_rs1_real   <= w_rs1_real_d;
      r_rs1_imag   <= w_rs1_imag_d;
      r_rs2        <= w_rs2_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_id    <= w_resp_id_d;
      r_resp_real  <= w_resp_real_d;
      r_resp_imag  <= w_resp_imag_d;
      r_cfg_err    <= w_cfg_err_d;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_acc_valid    = r_acc_valid;
  assign o_acc_insn     = r_acc_insn;
  assign o_acc_rs1_real = r_rs1_real;
  assign o_acc_rs1_imag = r_rs1_imag;
  assign o_acc_rs2      = r_rs2;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_id      = r_resp_id;
  assign o_resp_real    = r_resp_real;
  assign o_resp_imag    = r_resp_imag;
  assign o_cfg_err      = r_cfg_err;

`ifdef SCIE_SCHED_PERF_EN
  logic [31:0] r_perf_jobs, r_perf_busy;
  logic [15:0] r_perf_cfg;

  // Counters wrap naturally; cfg counts writes actually issued to the accelerator.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_jobs <= '0;
      r_perf_busy <= '0;
      r_perf_cfg  <= '0;
    end else begin
      if (r_state == StResp && r_resp_valid && i_resp_ready) r_perf_jobs <= r_perf_jobs + 32'd1;
      if (r_state != StIdle) r_perf_busy <= r_perf_busy + 32'd1;
      if (r_state == StCfg && w_idx_ok) r_perf_cfg <= r_perf_cfg + 16'd1;
    end
  end

  assign o_perf_jobs = r_perf_jobs;
  assign o_perf_busy = r_perf_busy;
  assign o_perf_cfg  = r_perf_cfg;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_scie_job_scheduler.sv
// tb_scie_job_scheduler
//   Directed bench for scie_job_scheduler (NUM_REQ=2, DATA_W=64). A stub accelerator returns
//   rd = 2 * rs1 captured on the last insn-43 cycle. Expected values are hand-computed constants.
module tb_scie_job_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, req_cfg;
  logic [5:0]   req_idx;
  logic [127:0] req_real, req_imag;
  logic         resp_valid, resp_ready;
  logic [0:0]   resp_id;
  logic [63:0]  resp_real, resp_imag;
  logic         cfg_err;
  logic         acc_valid;
  logic [31:0]  acc_insn, acc_rs2;
  logic [63:0]  acc_rs1_real, acc_rs1_imag;
  logic [63:0]  acc_rd_real, acc_rd_imag;
  logic [63:0]  stub_re = '0;
  logic [63:0]  stub_im = '0;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [63:0] CwRe  = 64'd40916663891;
  localparam logic [63:0] CwIm  = 64'd144455627928;
  localparam logic [63:0] CjRe  = 64'd8438427473;
  localparam logic [63:0] CjIm  = -64'sd55890852234;
  localparam logic [63:0] CjxRe = 64'd16876854946;
  localparam logic [63:0] CjxIm = -64'sd111781704468;
  localparam logic [63:0] R0Re  = 64'd100;
  localparam logic [63:0] R0Im  = -64'sd7;
  localparam logic [63:0] R1Re  = -64'sd2000;
  localparam logic [63:0] R1Im  = 64'd33;
  localparam logic [63:0] E0Re  = 64'd200;
  localparam logic [63:0] E0Im  = -64'sd14;
  localparam logic [63:0] E1Re  = -64'sd4000;
  localparam logic [63:0] E1Im  = 64'd66;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acc_valid && acc_insn == 32'd43) begin
      stub_re <= acc_rs1_real;
      stub_im <= acc_rs1_imag;
    end
  end
  assign acc_rd_real = stub_re * 64'd2;
  assign acc_rd_imag = stub_im * 64'd2;

  scie_job_scheduler dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_cfg      (req_cfg),
    .i_req_idx      (req_idx),
    .i_req_real     (req_real),
    .i_req_imag     (req_imag),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_id      (resp_id),
    .o_resp_real    (resp_real),
    .o_resp_imag    (resp_imag),
    .o_cfg_err      (cfg_err),
    .o_acc_valid    (acc_valid),
    .o_acc_insn     (acc_insn),
    .o_acc_rs1_real (acc_rs1_real),
    .o_acc_rs1_imag (acc_rs1_imag),
    .o_acc_rs2      (acc_rs2),
    .i_acc_rd_real  (acc_rd_real),
    .i_acc_rd_imag  (acc_rd_imag)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fail(input string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  // Bounded wait for a grant pulse; a timeout is recorded as a failed comparison.
  task automatic wait_ready(input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 2'b00 && k < max_cyc);
    n_asserts++;
    if (req_ready === 2'b00) fail("grant_seen");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_id;
    logic [63:0] exp_re, exp_im;
    logic        seen;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_cfg    = '0;
    req_idx    = '0;
    req_real   = '0;
    req_imag   = '0;
    resp_ready = 1'b0;
    tick(2);
    n_asserts++; if (req_ready !== 2'b00) fail("rst_req_ready");
    n_asserts++; if (acc_valid !== 1'b0) fail("rst_acc_valid");
    n_asserts++; if (acc_insn !== 32'd0) fail("rst_acc_insn");
    n_asserts++; if (resp_valid !== 1'b0) fail("rst_resp_valid");
    n_asserts++; if (resp_real !== 64'd0) fail("rst_resp_real");
    n_asserts++; if (cfg_err !== 1'b0) fail("rst_cfg_err");
    rst_n = 1'b1;
    tick(1);

    // Coefficient write, tap 3
    req_valid      = 2'b01;
    req_cfg        = 2'b01;
    req_idx[2:0]   = 3'd3;
    req_real[63:0] = CwRe;
    req_imag[63:0] = CwIm;
    wait_ready(10);
    n_asserts++; if (req_ready !== 2'b01) fail("cw_ready");
    req_valid = 2'b00;
    req_real  = '1;
    req_imag  = '1;
    tick(1);
    n_asserts++; if (acc_valid !== 1'b1) fail("cw_acc_valid");
    n_asserts++; if (acc_insn !== 32'd11) fail("cw_insn");
    n_asserts++; if (acc_rs2 !== 32'd3) fail("cw_rs2");
    n_asserts++; if (acc_rs1_real !== CwRe) fail("cw_rs1_real");
    n_asserts++; if (acc_rs1_imag !== CwIm) fail("cw_rs1_imag");
    n_asserts++; if (resp_valid !== 1'b0) fail("cw_no_resp");
    tick(1);
    n_asserts++; if (acc_valid !== 1'b0) fail("cw_valid_drop");

    // Bad index from requester 1
    req_valid = 2'b10;
    req_cfg   = 2'b10;
    req_idx   = 6'b101_000;
    wait_ready(10);
    n_asserts++; if (req_ready !== 2'b10) fail("bad_ready");
    req_valid = 2'b00;
    tick(1);
    n_asserts++; if (acc_valid !== 1'b0) fail("bad_acc_valid");
    n_asserts++; if (cfg_err !== 1'b1) fail("bad_cfg_err");
    tick(1);
    n_asserts++; if (cfg_err !== 1'b0) fail("bad_cfg_err_once");
    n_asserts++; if (acc_valid !== 1'b0) fail("bad_acc_valid2");

    // Fairness with backpressure: both requesters hold valid for four jobs
    req_cfg          = 2'b00;
    req_real[63:0]   = R0Re;
    req_imag[63:0]   = R0Im;
    req_real[127:64] = R1Re;
    req_imag[127:64] = R1Im;
    req_valid        = 2'b11;
    for (int j = 0; j < 4; j++) begin
      exp_id = (j % 2 == 1);
      exp_re = exp_id ? E1Re : E0Re;
      exp_im = exp_id ? E1Im : E0Im;
      wait_ready(20);
      n_asserts++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) fail("fair_grant");
      tick(5);
      for (int s = 0; s < 3; s++) begin
        n_asserts++; if (resp_valid !== 1'b1) fail("fair_resp_valid");
        n_asserts++; if (resp_id !== exp_id) fail("fair_resp_id");
        n_asserts++; if (resp_real !== exp_re) fail("fair_resp_real");
        n_asserts++; if (resp_imag !== exp_im) fail("fair_resp_imag");
        n_asserts++; if (req_ready !== 2'b00) fail("fair_no_grant_in_resp");
        tick(1);
      end
      resp_ready = 1'b1;
      if (j == 3) req_valid = 2'b00;
      tick(1);
      resp_ready = 1'b0;
      n_asserts++; if (resp_valid !== 1'b0) fail("fair_resp_clear");
    end

    // Compute job from requester 0
    req_valid      = 2'b01;
    req_cfg        = 2'b00;
    req_real[63:0] = CjRe;
    req_imag[63:0] = CjIm;
    wait_ready(10);
    n_asserts++; if (req_ready !== 2'b01) fail("cj_ready");
    req_valid = 2'b00;
    req_real  = '1;
    req_imag  = '1;
    tick(1);
    n_asserts++; if (acc_valid !== 1'b1) fail("cj_t1_valid");
    n_asserts++; if (acc_insn !== 32'd43) fail("cj_t1_insn");
    n_asserts++; if (acc_rs1_real !== CjRe) fail("cj_t1_rs1_real");
    n_asserts++; if (acc_rs1_imag !== CjIm) fail("cj_t1_rs1_imag");
    n_asserts++; if (acc_rs2 !== 32'd0) fail("cj_t1_rs2");
    tick(1);
    n_asserts++; if (acc_valid !== 1'b0) fail("cj_t2_bubble");
    n_asserts++; if (acc_insn !== 32'd43) fail("cj_t2_insn_hold");
    tick(1);
    n_asserts++; if (acc_valid !== 1'b1) fail("cj_t3_valid");
    n_asserts++; if (acc_insn !== 32'd91) fail("cj_t3_insn");
    tick(1);
    n_asserts++; if (acc_valid !== 1'b0) fail("cj_t4_valid");
    n_asserts++; if (resp_valid !== 1'b0) fail("cj_t4_no_resp");
    tick(1);
    n_asserts++; if (resp_valid !== 1'b1) fail("cj_t5_resp_valid");
    n_asserts++; if (resp_id !== 1'b0) fail("cj_t5_resp_id");
    n_asserts++; if (resp_real !== CjxRe) fail("cj_t5_resp_real");
    n_asserts++; if (resp_imag !== CjxIm) fail("cj_t5_resp_imag");
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    n_asserts++; if (resp_valid !== 1'b0) fail("cj_resp_clear");

    // Reset while the job sits in the bubble
    req_valid      = 2'b01;
    req_real[63:0] = R0Re;
    req_imag[63:0] = R0Im;
    wait_ready(10);
    n_asserts++; if (req_ready !== 2'b01) fail("rm_ready");
    req_valid = 2'b00;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    n_asserts++; if (acc_valid !== 1'b0) fail("rm_acc_valid");
    n_asserts++; if (acc_insn !== 32'd0) fail("rm_acc_insn");
    n_asserts++; if (acc_rs1_real !== 64'd0) fail("rm_rs1_real");
    n_asserts++; if (req_ready !== 2'b00) fail("rm_req_ready");
    tick(2);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      seen = seen | resp_valid;
    end
    n_asserts++; if (seen !== 1'b0) fail("rm_no_resp");
    req_valid = 2'b11;
    wait_ready(10);
    n_asserts++; if (req_ready !== 2'b01) fail("rm_regrant_req0");
    req_valid = 2'b00;
    tick(1);
    n_asserts++; if (acc_insn !== 32'd43) fail("rm_regrant_insn");
    n_asserts++; if (acc_rs1_real !== R0Re) fail("rm_regrant_rs1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
